// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: processes one bit pair per clock, LSB first,
// through a single full adder and reports {carry_out, sum} plus signed overflow.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               sum_bit;
    logic               carry_nxt;
    logic               last_bit;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    always_comb begin
        sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = maj3(a_sh[0], b_sh[0], carry);
        last_bit  = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh                <= a_sh >> 1;
                    b_sh                <= b_sh >> 1;
                    carry               <= carry_nxt;
                    cnt                 <= cnt + CNT_W'(1);
                    result[WIDTH-1:0]   <= {sum_bit, result[WIDTH-1:1]};
                    // On the MSB, carry holds the carry into it and carry_nxt the carry out.
                    if (last_bit) begin
                        result[WIDTH] <= carry_nxt;
                        overflow      <= carry ^ carry_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomised checks of serial_addsub at WIDTH=4 and WIDTH=16.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, sub4, busy4, done4, ovf4;
    logic [3:0]  a4, b4;
    logic [4:0]  res4;
    logic        start16, sub16, busy16, done16, ovf16;
    logic [15:0] a16, b16;
    logic [16:0] res16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .overflow(ovf4)
    );

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(res16), .overflow(ovf16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [32:0] res, output logic ovf);
        longint one = 1;
        longint mask, au, bu, full, sa, sb, sr;
        mask = (one << w) - 1;
        au   = longint'(a) & mask;
        bu   = longint'(b) & mask;
        full = s ? (au + ((~bu) & mask) + 1) : (au + bu);
        full = full & ((mask << 1) | 1);
        res  = full[32:0];
        sa   = (au >= (one << (w - 1))) ? au - (one << w) : au;
        sb   = (bu >= (one << (w - 1))) ? bu - (one << w) : bu;
        sr   = s ? (sa - sb) : (sa + sb);
        ovf  = (sr > (one << (w - 1)) - 1) || (sr < -(one << (w - 1)));
    endtask

    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [32:0] er, input logic eo, input string tag);
        int          n;
        logic        d, bz, ov;
        logic [32:0] r;
        if (w == 4) begin
            a4 = a[3:0]; b4 = b[3:0]; sub4 = s; start4 = 1'b1;
        end else begin
            a16 = a[15:0]; b16 = b[15:0]; sub16 = s; start16 = 1'b1;
        end
        tick();
        start4 = 1'b0;
        start16 = 1'b0;
        a4 = ~a4; b4 = ~b4; sub4 = ~sub4;
        a16 = ~a16; b16 = ~b16; sub16 = ~sub16;
        bz = (w == 4) ? busy4 : busy16;
        check({tag, " busy"}, 64'(bz), 64'(1));
        n = 0;
        d = 1'b0;
        while (!d && n <= 40) begin
            tick();
            n++;
            d = (w == 4) ? done4 : done16;
        end
        if (!d) begin
            check({tag, " timeout"}, 64'(0), 64'(1));
            return;
        end
        check({tag, " latency"}, 64'(n + 1), 64'(w + 1));
        r  = (w == 4) ? 33'(res4) : 33'(res16);
        ov = (w == 4) ? ovf4 : ovf16;
        check({tag, " result"}, 64'(r), 64'(er));
        check({tag, " overflow"}, 64'(ov), 64'(eo));
        tick();
        d  = (w == 4) ? done4 : done16;
        bz = (w == 4) ? busy4 : busy16;
        check({tag, " done drop"}, 64'(d), 64'(0));
        check({tag, " idle"}, 64'(bz), 64'(0));
    endtask

    initial begin
        logic [32:0] er;
        logic        eo;
        logic [32:0] exp_q[$];
        logic        exp_o[$];
        int          ndone;
        logic [31:0] ra, rb;
        logic        rs;

        rst = 1'b1;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", 64'(busy4), 64'(0));
        check("reset done", 64'(done4), 64'(0));
        check("reset result", 64'(res4), 64'(0));
        check("reset overflow", 64'(ovf4), 64'(0));
        check("reset busy16", 64'(busy16), 64'(0));

        // Directed WIDTH=4 vectors
        run_op(4, 5, 3, 1'b0, 33'b0_1000, 1'b1, "add 5+3");
        run_op(4, 15, 1, 1'b0, 33'b1_0000, 1'b0, "add 15+1");
        run_op(4, 3, 5, 1'b1, 33'b0_1110, 1'b0, "sub 3-5");
        run_op(4, 8, 1, 1'b1, 33'b1_0111, 1'b1, "sub 8-1");

        // Outputs hold while idle
        tick(); tick(); tick();
        check("hold result", 64'(res4), 64'(33'b1_0111));
        check("hold overflow", 64'(ovf4), 64'(1));

        // Reset wins over start on the same edge
        rst = 1'b1; start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        tick();
        rst = 1'b0; start4 = 1'b0;
        check("rst prio busy", 64'(busy4), 64'(0));
        check("rst prio result", 64'(res4), 64'(0));

        // start held high, operands changing every cycle
        ndone = 0;
        for (int i = 0; i < 18; i++) begin
            a4 = 4'((i * 3 + 1) & 15);
            b4 = 4'((i * 5 + 2) & 15);
            sub4 = (((i / 6) % 2) == 1) ^ ((i % 2) == 1);
            start4 = 1'b1;
            if (i % 6 == 0) begin
                model(4, 32'(a4), 32'(b4), sub4, er, eo);
                exp_q.push_back(er);
                exp_o.push_back(eo);
            end
            tick();
            check($sformatf("stream done %0d", i), 64'(done4), 64'((i % 6) == 4));
            if (done4) begin
                ndone++;
                if (exp_q.size() > 0) begin
                    check($sformatf("stream result %0d", i), 64'(res4), 64'(exp_q.pop_front()));
                    check($sformatf("stream overflow %0d", i), 64'(ovf4), 64'(exp_o.pop_front()));
                end
            end
        end
        start4 = 1'b0;
        check("stream done count", 64'(ndone), 64'(3));
        tick();
        tick();

        // Reset in the middle of SHIFT
        a4 = 4'd6; b4 = 4'd7; sub4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 64'(busy4), 64'(0));
        check("abort result", 64'(res4), 64'(0));
        check("abort overflow", 64'(ovf4), 64'(0));
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done4) ndone++;
            tick();
        end
        check("abort no done", 64'(ndone), 64'(0));
        run_op(4, 6, 7, 1'b0, 33'b0_1101, 1'b1, "add 6+7 after abort");

        // Random WIDTH=16
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom & 32'hFFFF;
            rb = $urandom & 32'hFFFF;
            rs = 1'($urandom_range(0, 1));
            model(16, ra, rb, rs, er, eo);
            run_op(16, ra, rb, rs, er, eo, $sformatf("rand16 #%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
